axi_lite_regfile: RTL and testbench
===================================

// Module: axi_lite_regfile
// PURPOSE
//   Parametrised AXI4-Lite slave register file between the PS AXI-Lite master and kernel engines.
//   Holds NUM_REGS 32-bit registers, each read-write or read-only (engine status).
//   Adds over the previous generation: byte strobes, AW/W accepted in any order, SLVERR decode, B/R backpressure.
//   Also emits a one-cycle command doorbell.
// PARAMETERS
//   ADDR_W     32            AXI address width
//   DATA_W     32            register/data width (multiple of 8)
//   NUM_REGS   8             number of registers (>=2)
//   BASE_ADDR  32'h43C8_0000 slave base address; reg i at BASE_ADDR + 4*i
//   RO_MASK    8'h01         bit i = 1: reg i read-only, reads status_i slice i
//   CMD_IDX    1             index of the command register (must be RW)
// PORTS
//   clk         in   1                  clock
//   rst         in   1                  synchronous reset, active-high
//   s_awvalid   in   1                  / s_awready out 1 / s_awaddr in ADDR_W: write address channel
//   s_wvalid    in   1                  / s_wready out 1 / s_wdata in DATA_W / s_wstrb in DATA_W/8: write data channel
//   s_bvalid    out  1                  / s_bready in 1 / s_bresp out 2: write response channel
//   s_arvalid   in   1                  / s_arready out 1 / s_araddr in ADDR_W: read address channel
//   s_rvalid    out  1                  / s_rready in 1 / s_rdata out DATA_W / s_rresp out 2: read data channel
//   status_i    in   NUM_REGS*DATA_W    live engine status; slice i is used when RO_MASK[i] = 1
//   regs_o      out  NUM_REGS*DATA_W    current RW register contents (RO slices drive 0)
//   cmd_o       out  8                  last command byte written to CMD_IDX
//   cmd_new_o   out  1                  one-cycle pulse per accepted command write
// BEHAVIOUR
//   Reset (rst=1 at posedge)
//     - All registers, cmd_o, cmd_new_o, bvalid, rvalid, bresp, rresp and rdata go to 0.
//     - All ready signals are 0 while rst is high; they rise in the first cycle after rst falls.
//     - A reset mid-transaction abandons any pending AW, W, B or R; no write commits.
//   Decode
//     - off = addr - BASE_ADDR (ADDR_W-bit modulo); idx = off >> 2.
//     - Error: off[1:0] != 0, or idx >= NUM_REGS (this includes addr < BASE, which wraps).
//   Write FSM: WAIT -> RESP -> WAIT
//     - WAIT: awready=1 until the AW handshake, then 0 with awaddr held; wready=1 until the W handshake, then 0 with wdata/wstrb held.
//     - AW and W may handshake in the same cycle or in either order.
//     - Once both are held, the next edge commits the write and sets bvalid=1 (state RESP).
//     - Latency: bvalid is asserted 1 cycle after the later of the AW/W handshakes.
//     - Commit: each byte lane b with wstrb[b]=1 of reg idx <= wdata lane b; lanes with wstrb[b]=0 are unchanged; bresp=OKAY (00).
//     - Error address or RO reg: no state change; bresp=SLVERR (10).
//     - RESP: bvalid and bresp are held stable until bready; at the handshake return to WAIT with awready=wready=1 on the next cycle.
//     - Doorbell: a committed write to CMD_IDX with wstrb[0]=1 sets cmd_o <= wdata[7:0] and pulses cmd_new_o for exactly 1 cycle, aligned with bvalid rising.
//     - A wstrb of all zeros commits nothing and gives OKAY with no doorbell.
//   Read FSM: IDLE -> DATA -> IDLE
//     - IDLE: arready=1; on the AR handshake the next edge sets rvalid=1 and arready=0. Latency 1 cycle.
//     - rdata source: RW reg -> register value at the AR handshake cycle; RO reg -> status_i slice sampled in that same cycle.
//     - rresp=OKAY for valid reads.
//     - Error address: rdata=32'hDEAD_BEEF (truncated/zero-extended to DATA_W), rresp=SLVERR.
//     - DATA: rdata/rresp are held stable until rready; arready returns to 1 on the cycle after the handshake.
//   Concurrency
//     - Read and write FSMs are independent.
//     - A read handshake in the same cycle as a write commit to the same reg returns the old value.
//     - At most one outstanding read and one outstanding write; no ID or reordering support.
// TESTING
//   1. Reset 3 cycles -> ready signals low during reset, then awready=wready=arready=1; regs_o=0; bvalid=rvalid=0.
//   2. AW to 0x43C8_0008, then W 0xA5A5_A5A5 with strb 4'hF two cycles later -> bvalid 1 cycle after W, bresp=00, reg2=0xA5A5_A5A5.
//   3. Reg2=0x1122_3344, write 0xFFFF_FFFF with strb 4'b0101 -> reg2=0x11FF_33FF.
//   4. Write 0x0000_00C3 to 0x43C8_0004 (AW+W same cycle) -> cmd_o=8'hC3, cmd_new_o high exactly 1 cycle, aligned with bvalid.
//   5. Read 0x43C8_0000 with status_i[0]=0xCAFE_0001 -> rdata=0xCAFE_0001, rresp=00. Write to that address -> bresp=10, no change.
//   6. Read 0x43C8_0040 and 0x43C8_0006 -> rdata=0xDEAD_BEEF, rresp=10. Hold rready=0 for 5 cycles -> rvalid and rdata stable.
//      Assert rst while bvalid=1 -> bvalid=0 next cycle.

Source files
------------

// File: rtl/axi_lite_regfile.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile
//   AXI4-Lite slave register file sitting between the PS AXI-Lite master and the
//   kernel engines. Holds NUM_REGS registers of DATA_W bits. Each register is
//   either read-write (software owned) or read-only (a live engine status slice).
//   Writes honour byte strobes and accept AW and W in either order. Bad
//   addresses and writes to read-only registers return SLVERR. B and R support
//   backpressure. A write to the command register emits a one-cycle doorbell.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_aw*                    write address channel (valid/ready/addr)
//   s_w*                     write data channel (valid/ready/data/strb)
//   s_b*                     write response channel (valid/ready/resp)
//   s_ar*                    read address channel (valid/ready/addr)
//   s_r*                     read data channel (valid/ready/data/resp)
//   status_i                 engine status, slice i is read when reg i is RO
//   regs_o                   RW register contents, RO slices drive 0
//   cmd_o                    last command byte written to CMD_IDX
//   cmd_new_o                one-cycle pulse per committed command write
// -----------------------------------------------------------------------------
module axi_lite_regfile #(
  parameter int                  ADDR_W    = 32,
  parameter int                  DATA_W    = 32,
  parameter int                  NUM_REGS  = 8,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = 32'h43C8_0000,
  parameter logic [NUM_REGS-1:0] RO_MASK   = 8'h01,
  parameter int                  CMD_IDX   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  // write address channel
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [ADDR_W-1:0]            s_awaddr,
  // write data channel
  input  logic                         s_wvalid,
  output logic                         s_wready,
  input  logic [DATA_W-1:0]            s_wdata,
  input  logic [DATA_W/8-1:0]          s_wstrb,
  // write response channel
  output logic                         s_bvalid,
  input  logic                         s_bready,
  output logic [1:0]                   s_bresp,
  // read address channel
  input  logic                         s_arvalid,
  output logic                         s_arready,
  input  logic [ADDR_W-1:0]            s_araddr,
  // read data channel
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [DATA_W-1:0]            s_rdata,
  output logic [1:0]                   s_rresp,
  // engine side
  input  logic [NUM_REGS*DATA_W-1:0]   status_i,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [7:0]                   cmd_o,
  output logic                         cmd_new_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);

  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [DATA_W-1:0] ERR_DATA    = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic { WR_WAIT, WR_RESP } wr_state_e;
  typedef enum logic { RD_IDLE, RD_DATA } rd_state_e;

  typedef struct packed {
    logic             err;
    logic [IDX_W-1:0] idx;
  } decode_t;

  // Offset is taken modulo 2^ADDR_W, so addresses below BASE_ADDR wrap to a
  // huge index and land in the out-of-range error case.
  function automatic decode_t decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    decode_t           d;
    off   = addr - BASE_ADDR;
    d.err = (off[1:0] != 2'b00) || ((off >> 2) >= ADDR_W'(NUM_REGS));
    d.idx = off[IDX_W+1:2];
    return d;
  endfunction

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  wr_state_e         wr_state;
  logic              aw_full;
  logic              w_full;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  rd_state_e         rd_state;

  decode_t wr_dec;
  decode_t rd_dec;
  logic    wr_err;

  assign wr_dec = decode(aw_addr_q);
  assign rd_dec = decode(s_araddr);
  // RO targets are rejected the same way as undecoded addresses.
  assign wr_err = wr_dec.err || RO_MASK[wr_dec.idx];

  // ---------------------------------------------------------------------------
  // Write path: collect AW and W independently, commit once both are held.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk) begin
    cmd_new_o <= 1'b0;
    if (rst) begin
      wr_state  <= WR_WAIT;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      cmd_o     <= '0;
      // NOTE: the register array is built from flops, not a RAM macro, so it
      // can be cleared in the same reset branch as the control state.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (wr_state)
        WR_WAIT: begin
          if (!aw_full) begin
            if (s_awvalid && s_awready) begin
              aw_addr_q <= s_awaddr;
              aw_full   <= 1'b1;
              s_awready <= 1'b0;
            end else begin
              s_awready <= 1'b1;
            end
          end

          if (!w_full) begin
            if (s_wvalid && s_wready) begin
              w_data_q <= s_wdata;
              w_strb_q <= s_wstrb;
              w_full   <= 1'b1;
              s_wready <= 1'b0;
            end else begin
              s_wready <= 1'b1;
            end
          end

          // Both halves captured on an earlier edge: commit now.
          if (aw_full && w_full) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            s_bvalid <= 1'b1;
            wr_state <= WR_RESP;
            if (wr_err) begin
              s_bresp <= RESP_SLVERR;
            end else begin
              s_bresp <= RESP_OKAY;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (!RO_MASK[i] && (wr_dec.idx == IDX_W'(i))) begin
                  for (int b = 0; b < STRB_W; b++) begin
                    if (w_strb_q[b]) begin
                      regs_q[i][8*b +: 8] <= w_data_q[8*b +: 8];
                    end
                  end
                end
              end
              if ((wr_dec.idx == IDX_W'(CMD_IDX)) && w_strb_q[0]) begin
                cmd_o     <= w_data_q[7:0];
                cmd_new_o <= 1'b1;
              end
            end
          end
        end

        WR_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            wr_state  <= WR_WAIT;
          end
        end

        default: wr_state <= WR_WAIT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: one outstanding read, data captured at the AR handshake.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= RD_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (s_arvalid && s_arready) begin
            s_arready <= 1'b0;
            s_rvalid  <= 1'b1;
            rd_state  <= RD_DATA;
            if (rd_dec.err) begin
              s_rdata <= ERR_DATA;
              s_rresp <= RESP_SLVERR;
            end else if (RO_MASK[rd_dec.idx]) begin
              s_rdata <= status_i[rd_dec.idx*DATA_W +: DATA_W];
              s_rresp <= RESP_OKAY;
            end else begin
              // Pre-edge value: a write committing on this same edge is not seen.
              s_rdata <= regs_q[rd_dec.idx];
              s_rresp <= RESP_OKAY;
            end
          end else begin
            s_arready <= 1'b1;
          end
        end

        RD_DATA: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
            rd_state  <= RD_IDLE;
          end
        end

        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register export: RO slices are driven to zero.
  // ---------------------------------------------------------------------------
  // NOTE: regs_o is given a full default before the loop so no path through
  // this block leaves a bit unassigned and no latch is inferred.
  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) begin
        regs_o[i*DATA_W +: DATA_W] = regs_q[i];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_regfile
//   Directed bench for axi_lite_regfile with default parameters (8 x 32-bit
//   registers, reg 0 read-only, command register at index 1). Inputs are driven
//   1 time unit after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_axi_lite_regfile;

  localparam int NR = 8;
  localparam int DW = 32;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_awvalid, s_awready;
  logic [31:0]     s_awaddr;
  logic            s_wvalid, s_wready;
  logic [31:0]     s_wdata;
  logic [3:0]      s_wstrb;
  logic            s_bvalid, s_bready;
  logic [1:0]      s_bresp;
  logic            s_arvalid, s_arready;
  logic [31:0]     s_araddr;
  logic            s_rvalid, s_rready;
  logic [31:0]     s_rdata;
  logic [1:0]      s_rresp;
  logic [NR*DW-1:0] status_i;
  logic [NR*DW-1:0] regs_o;
  logic [7:0]      cmd_o;
  logic            cmd_new_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_regs [NR];
  logic [1:0]  resp;

  always #5 clk = ~clk;

  axi_lite_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_awaddr  (s_awaddr),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_bresp   (s_bresp),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_araddr  (s_araddr),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .status_i  (status_i),
    .regs_o    (regs_o),
    .cmd_o     (cmd_o),
    .cmd_new_o (cmd_new_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] reg_of(input int i);
    return regs_o[i*DW +: DW];
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s_reg%0d", tag, i), reg_of(i), exp_regs[i]);
    end
  endtask

  // AW and W presented together; both readies are expected high.
  task automatic write_req(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    s_awvalid = 1'b1; s_awaddr = addr;
    s_wvalid  = 1'b1; s_wdata  = data; s_wstrb = strb;
    tick();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
  endtask

  // Wait (bounded) for bvalid, check its latency, then complete the B handshake.
  task automatic wait_b(input string tag, input int exp_lat, output logic [1:0] r);
    int lat = 0;
    while (!s_bvalid && lat < 16) begin
      tick();
      lat++;
    end
    check({tag, "_blat"}, lat, exp_lat);
    r = s_bresp;
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    check({tag, "_bdone"}, s_bvalid, 1'b0);
    check({tag, "_rdy_back"}, {s_awready, s_wready}, 2'b11);
  endtask

  task automatic write_full(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input string tag, input logic [1:0] exp_resp);
    logic [1:0] r;
    write_req(addr, data, strb);
    wait_b(tag, 1, r);
    check({tag, "_bresp"}, r, exp_resp);
  endtask

  task automatic read_full(input logic [31:0] addr, input string tag,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
    s_arvalid = 1'b1; s_araddr = addr;
    tick();
    s_arvalid = 1'b0;
    check({tag, "_rvalid"}, s_rvalid, 1'b1);
    check({tag, "_rdata"}, s_rdata, exp_data);
    check({tag, "_rresp"}, s_rresp, exp_resp);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    check({tag, "_rdone"}, s_rvalid, 1'b0);
    check({tag, "_arready"}, s_arready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    s_awvalid = 1'b0; s_awaddr = '0;
    s_wvalid  = 1'b0; s_wdata  = '0; s_wstrb = '0;
    s_bready  = 1'b0;
    s_arvalid = 1'b0; s_araddr = '0;
    s_rready  = 1'b0;
    status_i  = '0;
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;

    // 1. Reset for 3 cycles, readies low throughout, then high after release.
    repeat (3) begin
      tick();
      check("rst_readies", {s_awready, s_wready, s_arready}, 3'b000);
      check("rst_valids", {s_bvalid, s_rvalid, cmd_new_o}, 3'b000);
    end
    rst = 1'b0;
    tick();
    check("post_rst_readies", {s_awready, s_wready, s_arready}, 3'b111);
    check("post_rst_valids", {s_bvalid, s_rvalid}, 2'b00);
    check("post_rst_cmd", cmd_o, 8'h00);
    check_regs("post_rst");

    // 2. AW first, W two cycles later; bvalid one cycle after the W handshake.
    s_awvalid = 1'b1; s_awaddr = 32'h43C8_0008;
    tick();
    s_awvalid = 1'b0;
    check("t2_awready_held", s_awready, 1'b0);
    check("t2_wready_open", s_wready, 1'b1);
    tick();
    tick();
    s_wvalid = 1'b1; s_wdata = 32'hA5A5_A5A5; s_wstrb = 4'hF;
    tick();
    s_wvalid = 1'b0;
    check("t2_no_b_yet", s_bvalid, 1'b0);
    wait_b("t2", 1, resp);
    check("t2_bresp", resp, OKAY);
    exp_regs[2] = 32'hA5A5_A5A5;
    check("t2_reg2", reg_of(2), exp_regs[2]);

    // 2b. W first, AW a cycle later, partial strobe on upper lanes of reg6.
    s_wvalid = 1'b1; s_wdata = 32'hAABB_CCDD; s_wstrb = 4'b1100;
    tick();
    s_wvalid = 1'b0;
    check("t2b_wready_held", {s_awready, s_wready}, 2'b10);
    tick();
    check("t2b_no_b", s_bvalid, 1'b0);
    s_awvalid = 1'b1; s_awaddr = 32'h43C8_0018;
    tick();
    s_awvalid = 1'b0;
    wait_b("t2b", 1, resp);
    check("t2b_bresp", resp, OKAY);
    exp_regs[6] = 32'hAABB_0000;
    check("t2b_reg6", reg_of(6), exp_regs[6]);

    // 3. Byte strobes: only lanes 0 and 2 change.
    write_full(32'h43C8_0008, 32'h1122_3344, 4'hF, "t3a", OKAY);
    write_full(32'h43C8_0008, 32'hFFFF_FFFF, 4'b0101, "t3b", OKAY);
    exp_regs[2] = 32'h11FF_33FF;
    check("t3_reg2", reg_of(2), exp_regs[2]);

    // 4. Command doorbell aligned with bvalid, one cycle wide.
    write_req(32'h43C8_0004, 32'h0000_00C3, 4'hF);
    check("t4_pulse_early", {s_bvalid, cmd_new_o}, 2'b00);
    tick();
    check("t4_pulse_with_b", {s_bvalid, cmd_new_o}, 2'b11);
    check("t4_cmd", cmd_o, 8'hC3);
    tick();
    check("t4_pulse_gone", {s_bvalid, cmd_new_o}, 2'b10);
    wait_b("t4", 0, resp);
    check("t4_bresp", resp, OKAY);
    exp_regs[1] = 32'h0000_00C3;
    check("t4_reg1", reg_of(1), exp_regs[1]);

    // Zero strobe: OKAY, nothing changes, no new command byte.
    write_full(32'h43C8_0004, 32'h0000_0055, 4'h0, "t4z", OKAY);
    check("t4z_cmd", cmd_o, 8'hC3);
    check("t4z_reg1", reg_of(1), exp_regs[1]);

    // 5. RO register reads status, writes to it are rejected.
    status_i[31:0] = 32'hCAFE_0001;
    read_full(32'h43C8_0000, "t5_ro", 32'hCAFE_0001, OKAY);
    write_full(32'h43C8_0000, 32'hFFFF_FFFF, 4'hF, "t5_rowr", SLVERR);
    check_regs("t5_rowr");
    read_full(32'h43C8_0008, "t5_rw", 32'h11FF_33FF, OKAY);
    read_full(32'h43C8_001C, "t5_last", 32'h0000_0000, OKAY);
    write_full(32'h43C8_0020, 32'h1234_5678, 4'hF, "t5_oob_wr", SLVERR);
    check_regs("t5_oob_wr");

    // Read handshake on the same edge as a commit to that reg sees the old value.
    write_req(32'h43C8_0014, 32'h0BAD_F00D, 4'hF);
    s_arvalid = 1'b1; s_araddr = 32'h43C8_0014;
    tick();
    s_arvalid = 1'b0;
    check("conc_valids", {s_bvalid, s_rvalid}, 2'b11);
    check("conc_old_data", s_rdata, 32'h0000_0000);
    s_bready = 1'b1; s_rready = 1'b1;
    tick();
    s_bready = 1'b0; s_rready = 1'b0;
    check("conc_done", {s_bvalid, s_rvalid}, 2'b00);
    exp_regs[5] = 32'h0BAD_F00D;
    read_full(32'h43C8_0014, "conc_new", 32'h0BAD_F00D, OKAY);

    // 6. Error reads: out of range, misaligned, below base.
    read_full(32'h43C8_0040, "t6_oob", 32'hDEAD_BEEF, SLVERR);
    read_full(32'h43C8_0006, "t6_mis", 32'hDEAD_BEEF, SLVERR);
    read_full(32'h43C7_FFFC, "t6_below", 32'hDEAD_BEEF, SLVERR);

    // R backpressure: rvalid/rdata/rresp hold for 5 cycles with rready low.
    s_arvalid = 1'b1; s_araddr = 32'h43C8_0040;
    tick();
    s_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t6_hold%0d", i), {s_rvalid, s_arready, s_rresp, s_rdata},
            {1'b1, 1'b0, SLVERR, 32'hDEAD_BEEF});
      tick();
    end
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    check("t6_hold_done", {s_rvalid, s_arready}, 2'b01);

    // Reset while bvalid is high drops bvalid and clears the register file.
    write_req(32'h43C8_000C, 32'h1234_5678, 4'hF);
    tick();
    check("rst_b_pending", s_bvalid, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_b_dropped", s_bvalid, 1'b0);
    check("rst_mid_readies", {s_awready, s_wready, s_arready}, 3'b000);
    check("rst_mid_cmd", cmd_o, 8'h00);
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    check_regs("rst_mid");
    rst = 1'b0;
    tick();
    check("rst_mid_release", {s_awready, s_wready, s_arready}, 3'b111);

    // AW accepted, then reset: the held address is abandoned, a later W alone commits nothing.
    s_awvalid = 1'b1; s_awaddr = 32'h43C8_0010;
    tick();
    s_awvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    s_wvalid = 1'b1; s_wdata = 32'h7777_7777; s_wstrb = 4'hF;
    tick();
    s_wvalid = 1'b0;
    repeat (3) tick();
    check("abandon_no_b", s_bvalid, 1'b0);
    check("abandon_reg4", reg_of(4), 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
